// File: rtl/smart_house_pkg.sv
// Shared constants and helpers for the house sensor front end.
package smart_house_pkg;

  localparam int SENSOR_CH_MAX  = 16;
  localparam int EVT_IDX_W      = 4;
  localparam int STABLE_DEFAULT = 200;

  typedef logic [EVT_IDX_W-1:0] evt_idx_t;

  // Next round-robin index after idx, wrapping at ch channels.
  function automatic evt_idx_t next_idx(input evt_idx_t idx, input int ch);
    if (int'(idx) >= ch - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_debounce_ch.sv
// One debounce slice: stability counter, debounced level, pending-event bit
// and, when OVR_EN is set, a sticky lost-event flag.
module debounce_ch #(
  parameter int CNT_W  = 8,
  parameter int STABLE = 200,
  parameter bit OVR_EN = 1'b0
) (
  input  logic clk,
  input  logic arst,
  input  logic tick,
  input  logic clear,
  input  logic raw,
  input  logic pend_clr,
  output logic state_o,
  output logic pending_o,
  output logic overrun_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_pending;
  logic             w_mismatch;
  logic             w_toggle;

  assign w_mismatch = raw ^ r_state;
  assign w_toggle   = tick & w_mismatch & (r_cnt == LAST) & ~clear;

  // Count consecutive mismatching ticks; flip the level after STABLE of them.
  // A new toggle re-raises pending even if the arbiter clears it this cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_pending <= 1'b0;
    end else if (clear) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (tick) begin
        if (!w_mismatch) begin
          r_cnt <= '0;
        end else if (w_toggle) begin
          r_cnt   <= '0;
          r_state <= ~r_state;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_toggle) begin
        r_pending <= 1'b1;
      end else if (pend_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign state_o   = r_state;
  assign pending_o = r_pending;

  generate
    if (OVR_EN) begin : g_ovr
      logic r_ovr;
      // A toggle while the previous change is still unreported loses an event.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          r_ovr <= 1'b0;
        end else if (clear) begin
          r_ovr <= 1'b0;
        end else if (w_toggle && r_pending) begin
          r_ovr <= 1'b1;
        end
      end
      assign overrun_o = r_ovr;
    end else begin : g_no_ovr
      assign overrun_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sensor_debounce.sv
// Multi-channel sensor debouncer with a round-robin valid/ready event stream.
// Optional build macro SENSOR_DEBOUNCE_OVERRUN_EN enables the sticky
// per-channel overrun flags; without it overrun_o is constant zero.
module sensor_debounce
  import smart_house_pkg::*;
#(
  parameter int CH     = 4,
  parameter int CNT_W  = 8,
  parameter int STABLE = STABLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 tick,
  input  logic                 clear,
  input  logic [CH-1:0]        raw,
  output logic [CH-1:0]        state_o,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [EVT_IDX_W-1:0] evt_ch,
  output logic                 evt_level,
  output logic [CH-1:0]        overrun_o
);

`ifdef SENSOR_DEBOUNCE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic [CH-1:0] w_state;
  logic [CH-1:0] w_pending;
  logic [CH-1:0] w_pend_clr;
  logic [CH-1:0] w_ovr;
  logic [CH-1:0] w_hi_mask;
  logic [CH-1:0] w_req;
  logic [CH-1:0] w_win_oh;
  evt_idx_t      w_win_idx;
  logic          w_win_level;
  logic          w_load;
  logic          w_any;

  logic          r_valid;
  evt_idx_t      r_ch;
  logic          r_level;
  evt_idx_t      r_ptr;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_ch
      debounce_ch #(
        .CNT_W  (CNT_W),
        .STABLE (STABLE),
        .OVR_EN (OVR_EN)
      ) u_ch (
        .clk       (clk),
        .arst      (arst),
        .tick      (tick),
        .clear     (clear),
        .raw       (raw[g]),
        .pend_clr  (w_pend_clr[g]),
        .state_o   (w_state[g]),
        .pending_o (w_pending[g]),
        .overrun_o (w_ovr[g])
      );
    end
  endgenerate

  // Round-robin pick: lowest pending channel at or above the pointer, else
  // lowest pending channel overall.
  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < CH; i++) begin
      w_hi_mask[i] = (i >= int'(r_ptr));
    end
    w_req       = (|(w_pending & w_hi_mask)) ? (w_pending & w_hi_mask) : w_pending;
    w_win_oh    = '0;
    w_win_idx   = '0;
    w_win_level = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_win_oh    = CH'(1) << i;
        w_win_idx   = EVT_IDX_W'(i);
        w_win_level = w_state[i];
      end
    end
  end

  assign w_any      = |w_pending;
  assign w_load     = ~r_valid | evt_ready;
  assign w_pend_clr = (w_load && !clear) ? w_win_oh : '0;

  // Event output register: refill whenever empty or being consumed.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_level <= 1'b0;
      r_ptr   <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_level <= 1'b0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_ch    <= w_win_idx;
        r_level <= w_win_level;
        r_ptr   <= next_idx(w_win_idx, CH);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign state_o   = w_state;
  assign evt_valid = r_valid;
  assign evt_ch    = r_ch;
  assign evt_level = r_level;
  assign overrun_o = w_ovr;

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce with a cycle-level reference model.
module tb_sensor_debounce;

  localparam int CH     = 4;
  localparam int CNT_W  = 8;
  localparam int STABLE = 3;

`ifdef SENSOR_DEBOUNCE_OVERRUN_EN
  localparam logic [CH-1:0] EXP_OVR = 4'b0100;
`else
  localparam logic [CH-1:0] EXP_OVR = 4'b0000;
`endif

  logic          clk       = 1'b0;
  logic          arst      = 1'b1;
  logic          tick      = 1'b0;
  logic          clear     = 1'b0;
  logic          evt_ready = 1'b0;
  logic [CH-1:0] raw       = '0;
  logic [CH-1:0] state_o;
  logic          evt_valid;
  logic [3:0]    evt_ch;
  logic          evt_level;
  logic [CH-1:0] overrun_o;

  sensor_debounce #(.CH(CH), .CNT_W(CNT_W), .STABLE(STABLE)) dut (
    .clk       (clk),
    .arst      (arst),
    .tick      (tick),
    .clear     (clear),
    .raw       (raw),
    .state_o   (state_o),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel a count of consecutive mismatching ticks,
  // the accepted level and whether a change still awaits reporting.
  int m_run[CH];
  bit m_lvl[CH];
  bit m_pend[CH];
  bit m_ovr[CH];
  bit m_valid = 1'b0;
  int m_ch    = 0;
  bit m_elev  = 1'b0;
  int m_ptr   = 0;

  always @(posedge clk or posedge arst) begin : model
    bit old_lvl[CH];
    bit old_pend[CH];
    bit flip[CH];
    int win;
    bit can_load;
    if (arst) begin
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 0; m_lvl[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_valid = 0; m_ch = 0; m_elev = 0; m_ptr = 0;
    end else if (clear) begin
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_valid = 0; m_ch = 0; m_elev = 0; m_ptr = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        old_lvl[i]  = m_lvl[i];
        old_pend[i] = m_pend[i];
        flip[i]     = 0;
      end
      can_load = !m_valid || evt_ready;
      win = -1;
      for (int k = CH - 1; k >= 0; k--) begin
        if (old_pend[(m_ptr + k) % CH]) win = (m_ptr + k) % CH;
      end
      for (int i = 0; i < CH; i++) begin
        if (tick) begin
          if (raw[i] != old_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE) begin
              flip[i] = 1; m_lvl[i] = !old_lvl[i]; m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      if (can_load && win >= 0) m_pend[win] = 0;
      for (int i = 0; i < CH; i++) begin
        if (flip[i]) m_pend[i] = 1;
`ifdef SENSOR_DEBOUNCE_OVERRUN_EN
        if (flip[i] && old_pend[i]) m_ovr[i] = 1;
`endif
      end
      if (can_load) begin
        if (win >= 0) begin
          m_valid = 1; m_ch = win; m_elev = old_lvl[win]; m_ptr = (win + 1) % CH;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [CH-1:0] es, eo;
    if (chk_en && !arst) begin
      for (int i = 0; i < CH; i++) begin
        es[i] = m_lvl[i];
        eo[i] = m_ovr[i];
      end
      check("model_state", 32'(state_o), 32'(es));
      check("model_valid", 32'(evt_valid), 32'(m_valid));
      check("model_overrun", 32'(overrun_o), 32'(eo));
      if (m_valid) begin
        check("model_ch", 32'(evt_ch), 32'(m_ch));
        check("model_level", 32'(evt_level), 32'(m_elev));
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    check("rst_state", 32'(state_o), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_ch", 32'(evt_ch), 32'h0);
    check("rst_level", 32'(evt_level), 32'h0);
    check("rst_overrun", 32'(overrun_o), 32'h0);
    arst = 1'b0;
    chk_en = 1'b1;

    // Single channel acceptance and latency
    raw = 4'b0001;
    ticks(2);
    check("t1_not_yet", 32'(state_o), 32'h0);
    ticks(1);
    check("t1_accept", 32'(state_o), 32'h1);
    check("t1_valid_late", 32'(evt_valid), 32'h0);
    idle(1);
    check("t1_valid", 32'(evt_valid), 32'h1);
    check("t1_ch", 32'(evt_ch), 32'h0);
    check("t1_level", 32'(evt_level), 32'h1);
    idle(5);
    check("t1_hold_valid", 32'(evt_valid), 32'h1);
    check("t1_hold_ch", 32'(evt_ch), 32'h0);
    check("t1_hold_level", 32'(evt_level), 32'h1);
    evt_ready = 1'b1;
    idle(1);
    check("t1_consumed", 32'(evt_valid), 32'h0);

    // Glitch shorter than the stability window
    raw = 4'b0011;
    ticks(2);
    raw = 4'b0001;
    ticks(3);
    check("t2_glitch_state", 32'(state_o), 32'h1);
    check("t2_glitch_valid", 32'(evt_valid), 32'h0);

    // All channels at once, emitted round-robin from pointer 0
    raw = 4'b0000;
    ticks(3);
    idle(2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("t3_clear_state", 32'(state_o), 32'h0);
    raw = 4'hF;
    ticks(3);
    check("t3_all_state", 32'(state_o), 32'hF);
    for (int k = 0; k < CH; k++) begin
      idle(1);
      check("t3_burst_valid", 32'(evt_valid), 32'h1);
      check("t3_burst_ch", 32'(evt_ch), 32'(k));
      check("t3_burst_level", 32'(evt_level), 32'h1);
    end
    idle(1);
    check("t3_burst_done", 32'(evt_valid), 32'h0);

    // Repeated toggles of ch2 with the consumer stalled
    evt_ready = 1'b0;
    raw = 4'b1011;
    ticks(3);
    raw = 4'hF;
    ticks(3);
    raw = 4'b1011;
    ticks(3);
    idle(1);
    check("t4_overrun", 32'(overrun_o), 32'(EXP_OVR));
    check("t4_held_ch", 32'(evt_ch), 32'h2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("t4_clr_overrun", 32'(overrun_o), 32'h0);
    check("t4_clr_valid", 32'(evt_valid), 32'h0);
    check("t4_clr_state", 32'(state_o), 32'hB);

    // Asynchronous reset mid-count and mid-handshake
    raw = 4'b1010;
    ticks(3);
    idle(1);
    check("t5_pre_valid", 32'(evt_valid), 32'h1);
    raw = 4'hF;
    ticks(2);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("t5_arst_state", 32'(state_o), 32'h0);
    check("t5_arst_valid", 32'(evt_valid), 32'h0);
    check("t5_arst_ch", 32'(evt_ch), 32'h0);
    check("t5_arst_level", 32'(evt_level), 32'h0);
    @(negedge clk);
    arst = 1'b0;
    ticks(2);
    check("t5_recount", 32'(state_o), 32'h0);
    ticks(1);
    check("t5_accept", 32'(state_o), 32'hF);
    evt_ready = 1'b1;
    idle(6);
    check("t5_drained", 32'(evt_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_debounce.md
# sensor_debounce

Multi-channel debouncer and event generator for the house sensor inputs (door contacts, PIR, window switches). It sits directly downstream of the per-bit DFlop input registers: it consumes their registered outputs and filters each bit against a tick-based stability window. It also arbitrates level changes into a single valid/ready event stream for the controller FSM.

## Interface
Parameters:
- CH, 4, number of sensor channels (1..16)
- CNT_W, 8, debounce counter width
- STABLE, 200, consecutive mismatching ticks required to accept a change (2..2^CNT_W-1)

Ports:
- clk  in  1  clock, all logic on posedge
- arst  in  1  asynchronous reset, active-high, clears all state
- tick  in  1  sample strobe, one clk wide; counters advance only when high
- clear  in  1  synchronous clear of counters, pending bits and event register (states kept)
- raw  in  CH  registered sensor bits from the DFlop stage
- state_o  out  CH  debounced level per channel
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_ch  out  4  channel index of event
- evt_level  out  1  new debounced level of evt_ch
- overrun_o  out  CH  sticky per-channel lost-event flag (see Configuration)

## Operation
- Per channel: counter cnt, level state, pending bit.
- On tick with raw[i] != state[i]: if cnt == STABLE-1 then state[i] toggles, cnt <= 0, pending[i] <= 1; else cnt++.
- On tick with raw[i] == state[i]: cnt <= 0 (glitch rejected).
- No tick: cnt, state hold.
- Arbiter: round-robin over pending, pointer starts at 0, advances to winner+1 (mod CH) on each load.
- Output register loads when evt_valid == 0 or (evt_valid && evt_ready); loads winner index and its current state; pending[winner] cleared on load.
- Payload (evt_ch, evt_level) stable while evt_valid && !evt_ready.
- Simultaneous pending set and clear on same channel: set wins (new change re-raises pending).
- clear: cnt <= 0, pending <= 0, evt_valid <= 0, pointer <= 0; state_o unchanged; clear has priority over tick and handshake.

## Timing
- Reset (arst): state_o = 0, evt_valid = 0, evt_ch = 0, evt_level = 0, overrun_o = 0, all cnt = 0, pointer = 0.
- Acceptance latency: state_o flips on the clk edge of the STABLE-th consecutive mismatching tick.
- pending set same edge; evt_valid high at earliest the following edge.
- Back-to-back events: one per clk when evt_ready held high.
- arst mid-handshake: event is dropped, no replay.
- All CH channels changing on the same tick: events emitted in round-robin order from pointer, CH cycles with ready high.

## Configuration
- SENSOR_DEBOUNCE_OVERRUN_EN defined: overrun_o[i] set when state[i] toggles while pending[i] already 1; cleared only by arst or clear.
- Undefined: overrun_o tied to 0, no detection logic.

## Structure
- smart_house_pkg: SENSOR_CH_MAX = 16, event index width constant, default STABLE value.
- Sub-module debounce_ch (one counter/state/pending slice), instantiated CH times via generate; arbiter and output register in top.

## Test plan
- STABLE=3, raw[0] 0->1 held: state_o[0] = 1 on the 3rd tick edge; evt_valid next cycle with evt_ch=0, evt_level=1.
- raw[1] high for 2 ticks then low: state_o stays 0, no event.
- raw[3:0]=4'hF on same tick, evt_ready=1: four events evt_ch 0,1,2,3 on consecutive cycles.
- evt_ready=0 for 5 cycles with event pending: evt_valid, evt_ch, evt_level stable, then one handshake clears it.
- With OVERRUN_EN: ch2 toggles twice while evt_ready=0 -> overrun_o[2]=1 until clear; without macro -> overrun_o stays 0.
- arst asserted mid-count and during evt_valid: all outputs 0 immediately; after release, full STABLE ticks needed for acceptance.
